// File: rtl/sm_trace_buffer_pkg.sv
// Shared types and constants for the instruction-trace capture block.
package sm_trace_pkg;

  // One trace entry is {pc, instr}
  localparam int unsigned TRACE_ENTRY_W = 64;

  typedef logic [TRACE_ENTRY_W-1:0] trace_entry_t;

  // Capture state machine
  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    POST   = 2'd1,
    FROZEN = 2'd2
  } trace_state_e;

endpackage

// File: rtl/sm_trace_buffer_if.sv
// Capture/readout bundle of sm_trace_buffer. The master side is the CPU tap plus host,
// the slave side is the trace buffer itself.
interface sm_trace_buffer_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  import sm_trace_pkg::*;

  logic                     cpuEn;
  logic [31:0]              pc;
  logic [31:0]              instr;
  logic                     trigger;
  logic                     rearm;
  logic                     rdReq;
  logic                     rdValid;
  logic [TRACE_ENTRY_W-1:0] rdData;
  logic [DEPTH_LOG2:0]      count;
  logic                     frozen;

  modport master (
    output cpuEn, pc, instr, trigger, rearm, rdReq,
    input  rdValid, rdData, count, frozen
  );

  modport slave (
    input  cpuEn, pc, instr, trigger, rearm, rdReq,
    output rdValid, rdData, count, frozen
  );

endinterface

// File: rtl/sm_trace_buffer_ram.sv
// Simple dual-port synchronous RAM for trace entries: one write port, one read port with
// a registered output. The read register only updates on an enabled read so the host
// sees the last popped entry held steady.
module sm_trace_ram
  import sm_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr_en,
  input  logic [DEPTH_LOG2-1:0]    i_wr_addr,
  input  logic [TRACE_ENTRY_W-1:0] i_wr_data,
  input  logic                     i_rd_en,
  input  logic [DEPTH_LOG2-1:0]    i_rd_addr,
  output logic [TRACE_ENTRY_W-1:0] o_rd_data
);

  logic [TRACE_ENTRY_W-1:0] r_mem [0:(2**DEPTH_LOG2)-1];
  logic [TRACE_ENTRY_W-1:0] r_rd_data;

  // Storage array: no reset, contents are masked by the entry count
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Read register: 1-cycle latency, holds between reads, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sm_trace_buffer.sv
// Instruction-trace capture stage. Records {pc, instr} on every CPU-enabled cycle into a
// circular buffer, stops POST_COUNT captures after the triggering capture, then lets the
// host pop the frozen history oldest-first.
// Optional build macro SM_TRACE_NOP_FILTER_EN: when defined, cycles with instr == 0 are
// neither captured nor counted toward the post-trigger window, and cannot trigger.
module sm_trace_buffer
  import sm_trace_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned POST_COUNT = 8
) (
  input logic              clk,
  input logic              rst_n,
  sm_trace_buffer_if.slave io_trace
);

  localparam logic [DEPTH_LOG2:0]   CountFull = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PostLoad  = DEPTH_LOG2'(POST_COUNT);
  localparam logic [DEPTH_LOG2-1:0] PostLast  = DEPTH_LOG2'(1);

  trace_state_e              r_state;
  logic                      r_frozen;
  logic [DEPTH_LOG2-1:0]     r_post_cnt;
  logic [DEPTH_LOG2-1:0]     r_wr_ptr;
  logic [DEPTH_LOG2-1:0]     r_rd_ptr;
  logic [DEPTH_LOG2:0]       r_count;
  logic                      r_rd_valid;

  logic                      w_keep;
  logic                      w_cap;
  logic                      w_rd;
  logic                      w_full;
  logic [TRACE_ENTRY_W-1:0]  w_rd_data;

`ifdef SM_TRACE_NOP_FILTER_EN
  assign w_keep = (io_trace.instr != 32'h0);
`else
  assign w_keep = 1'b1;
`endif

  // A capture happens on a kept CPU cycle while recording; rearm wins over everything
  assign w_cap  = io_trace.cpuEn & w_keep & ~io_trace.rearm & (r_state != FROZEN);
  // A pop is accepted only from a frozen, non-empty buffer
  assign w_rd   = io_trace.rdReq & ~io_trace.rearm & (r_state == FROZEN) & (r_count != '0);
  assign w_full = (r_count == CountFull);

  // Capture FSM: trigger/post-window tracking and the registered frozen flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ARMED;
      r_frozen   <= 1'b0;
      r_post_cnt <= '0;
    end else if (io_trace.rearm) begin
      r_state    <= ARMED;
      r_frozen   <= 1'b0;
      r_post_cnt <= '0;
    end else if (w_cap) begin
      unique case (r_state)
        ARMED: begin
          // Trigger only counts when its cycle is actually stored
          if (io_trace.trigger) begin
            if (POST_COUNT == 0) begin
              r_state  <= FROZEN;
              r_frozen <= 1'b1;
            end else begin
              r_post_cnt <= PostLoad;
              r_state    <= POST;
            end
          end
        end
        POST: begin
          r_post_cnt <= r_post_cnt - 1'b1;
          if (r_post_cnt == PostLast) begin
            r_state  <= FROZEN;
            r_frozen <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pointers and occupancy; a full buffer drags the read pointer along on each capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (io_trace.rearm) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_cap) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_full) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end else if (w_rd) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count  <= r_count - 1'b1;
    end
  end

  // Read-valid strobe tracks the RAM's 1-cycle read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
    end
  end

  sm_trace_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_cap),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({io_trace.pc, io_trace.instr}),
    .i_rd_en   (w_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign io_trace.rdValid = r_rd_valid;
  assign io_trace.rdData  = w_rd_data;
  assign io_trace.count   = r_count;
  assign io_trace.frozen  = r_frozen;

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Self-checking bench for sm_trace_buffer. Two instances (post window 2 and 0) share one
// stimulus stream; a queue-based model per instance predicts every output each cycle.
module tb_sm_trace_buffer;
  import sm_trace_pkg::*;

  localparam int unsigned DepthLog2 = 4;
  localparam int          Depth     = 1 << DepthLog2;
`ifdef SM_TRACE_NOP_FILTER_EN
  localparam bit Filt = 1'b1;
`else
  localparam bit Filt = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cpu_en;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        trigger;
  logic        rearm;
  logic        rd_req;
  logic [31:0] nop_seq [4];

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  sm_trace_buffer_if #(.DEPTH_LOG2(DepthLog2)) if_a ();
  sm_trace_buffer_if #(.DEPTH_LOG2(DepthLog2)) if_b ();

  assign if_a.cpuEn   = cpu_en;
  assign if_a.pc      = pc;
  assign if_a.instr   = instr;
  assign if_a.trigger = trigger;
  assign if_a.rearm   = rearm;
  assign if_a.rdReq   = rd_req;
  assign if_b.cpuEn   = cpu_en;
  assign if_b.pc      = pc;
  assign if_b.instr   = instr;
  assign if_b.trigger = trigger;
  assign if_b.rearm   = rearm;
  assign if_b.rdReq   = rd_req;

  sm_trace_buffer #(.DEPTH_LOG2(DepthLog2), .POST_COUNT(2)) u_dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_trace (if_a)
  );

  sm_trace_buffer #(.DEPTH_LOG2(DepthLog2), .POST_COUNT(0)) u_dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .io_trace (if_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: history as a bounded queue, mode 0=recording 1=post 2=frozen
  for (genvar g = 0; g < 2; g++) begin : g_model
    localparam int Post = (g == 0) ? 2 : 0;
    logic [63:0] q[$];
    int          mode;
    int          left;
    int          m_count;
    bit          m_valid;
    logic [63:0] m_data;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        mode    = 0;
        left    = 0;
        m_valid = 1'b0;
        m_data  = '0;
      end else if (rearm) begin
        q.delete();
        mode    = 0;
        left    = 0;
        m_valid = 1'b0;
      end else begin
        m_valid = 1'b0;
        if (mode == 2 && rd_req && q.size() > 0) begin
          m_data  = q.pop_front();
          m_valid = 1'b1;
        end
        if (cpu_en && mode != 2 && !(Filt && instr == 32'h0)) begin
          q.push_back({pc, instr});
          if (q.size() > Depth) void'(q.pop_front());
          if (mode == 0 && trigger) begin
            if (Post == 0) mode = 2;
            else begin
              mode = 1;
              left = Post;
            end
          end else if (mode == 1) begin
            left--;
            if (left == 0) mode = 2;
          end
        end
      end
      m_count = q.size();
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("a_rdValid", 64'(if_a.rdValid), 64'(g_model[0].m_valid));
      check("a_rdData",  if_a.rdData,       g_model[0].m_data);
      check("a_count",   64'(if_a.count),   64'(g_model[0].m_count));
      check("a_frozen",  64'(if_a.frozen),  64'(g_model[0].mode == 2));
      check("b_rdValid", 64'(if_b.rdValid), 64'(g_model[1].m_valid));
      check("b_rdData",  if_b.rdData,       g_model[1].m_data);
      check("b_count",   64'(if_b.count),   64'(g_model[1].m_count));
      check("b_frozen",  64'(if_b.frozen),  64'(g_model[1].mode == 2));
    end
  end

  function automatic logic [63:0] ent(input int k);
    return {32'(k), 32'h1000_0000 + 32'(k)};
  endfunction

  task automatic drive(input bit en, input logic [31:0] p, input logic [31:0] ins,
                       input bit trg, input bit rea, input bit rd);
    cpu_en  = en;
    pc      = p;
    instr   = ins;
    trigger = trg;
    rearm   = rea;
    rd_req  = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    nop_seq[0] = 32'h2402_0005;
    nop_seq[1] = 32'h0;
    nop_seq[2] = 32'h0;
    nop_seq[3] = 32'h0000_0021;
    rst_n   = 1'b0;
    cpu_en  = 1'b0;
    pc      = '0;
    instr   = '0;
    trigger = 1'b0;
    rearm   = 1'b0;
    rd_req  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdValid", 64'(if_a.rdValid), 64'd0);
    check("reset_rdData",  if_a.rdData,       64'd0);
    check("reset_count",   64'(if_a.count),   64'd0);
    check("reset_frozen",  64'(if_a.frozen),  64'd0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Five captures, trigger on pc=2
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'(k), 32'h1000_0000 + 32'(k), k == 2, 1'b0, 1'b0);
      if (k == 3) check("t1_a_frozen_early", 64'(if_a.frozen), 64'd0);
    end
    check("t1_a_frozen", 64'(if_a.frozen), 64'd1);
    check("t1_a_count",  64'(if_a.count),  64'd5);
    check("t1_b_count",  64'(if_b.count),  64'd3);
    check("t1_model_a_count", 64'(g_model[0].m_count), 64'd5);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("t1_a_rd_valid", 64'(if_a.rdValid), 64'd1);
      check("t1_a_rd_data",  if_a.rdData,       ent(k));
    end
    check("t1_a_count_empty", 64'(if_a.count), 64'd0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("t1_a_rd_idle", 64'(if_a.rdValid), 64'd0);
    check("t1_a_rd_hold", if_a.rdData,       ent(4));

    // Wrap: 20 captures into 16 entries, trigger on the last
    drive(1'b1, 32'd99, 32'h1000_0063, 1'b0, 1'b1, 1'b0);
    check("t2_b_count_rearm",  64'(if_b.count),  64'd0);
    check("t2_b_frozen_rearm", 64'(if_b.frozen), 64'd0);
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 32'(k), 32'h1000_0000 + 32'(k), k == 19, 1'b0, 1'b0);
    end
    check("t2_b_count",  64'(if_b.count),  64'd16);
    check("t2_b_frozen", 64'(if_b.frozen), 64'd1);
    check("t2_a_frozen", 64'(if_a.frozen), 64'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("t2_b_rd_data", if_b.rdData, ent(4 + k));
    end

    // Alternating cpuEn: only even pcs stored
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      drive((k % 2) == 0, 32'(k), 32'h1000_0000 + 32'(k), k == 8, 1'b0, 1'b0);
    end
    check("t3_b_count",  64'(if_b.count),  64'd5);
    check("t3_b_frozen", 64'(if_b.frozen), 64'd1);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      check("t3_b_rd_data", if_b.rdData, ent(2 * k));
    end
    check("t3_b_count_left", 64'(if_b.count), 64'd3);

    // rearm beats a simultaneous read
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    check("t4_b_rdValid", 64'(if_b.rdValid), 64'd0);
    check("t4_b_count",   64'(if_b.count),   64'd0);
    check("t4_b_frozen",  64'(if_b.frozen),  64'd0);
    drive(1'b1, 32'd7, 32'h1000_0007, 1'b0, 1'b0, 1'b0);
    check("t4_b_armed_count", 64'(if_b.count), 64'd1);

    // Nop stream
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'(40 + k), nop_seq[k], k == 3, 1'b0, 1'b0);
    end
    check("t5_b_count",  64'(if_b.count),  Filt ? 64'd2 : 64'd4);
    check("t5_b_frozen", 64'(if_b.frozen), 64'd1);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("t5_b_rd0_instr", 64'(if_b.rdData[31:0]), 64'h2402_0005);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check("t5_b_rd1_instr", 64'(if_b.rdData[31:0]), Filt ? 64'h21 : 64'h0);
    repeat (2) drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset during the post window
    drive(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 32'(k), 32'h1000_0000 + 32'(k), k == 6, 1'b0, 1'b0);
    end
    check("t6_a_count",  64'(if_a.count),  64'd7);
    check("t6_a_frozen", 64'(if_a.frozen), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_a_rdValid", 64'(if_a.rdValid), 64'd0);
    check("t6_rst_a_rdData",  if_a.rdData,       64'd0);
    check("t6_rst_a_count",   64'(if_a.count),   64'd0);
    check("t6_rst_a_frozen",  64'(if_a.frozen),  64'd0);
    check("t6_rst_b_rdData",  if_b.rdData,       64'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(100 + k), 32'h1000_0000 + 32'(100 + k), k == 0, 1'b0, 1'b0);
    end
    check("t6_a_restart_count",  64'(if_a.count),  64'd3);
    check("t6_a_restart_frozen", 64'(if_a.frozen), 64'd1);
    check("t6_b_restart_count",  64'(if_b.count),  64'd1);

    // Randomized traffic checked by the per-cycle model comparison
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom,
            ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom,
            $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
            $urandom_range(0, 1) == 1);
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sm_trace_buffer.md
# sm_trace_buffer

Hardware instruction-trace capture stage that sits directly downstream of `sm_top`. Each CPU-enabled cycle, it records the current word PC and fetched instruction into a circular buffer. It stops after a trigger plus a programmable post-trigger window, then lets a host drain the frozen history oldest-first through a request/valid read port. It gives the on-silicon equivalent of the simulation cycle log, and is fed from the `regData` PC and `instr` signals.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: buffer holds 2^DEPTH_LOG2 entries.
- `POST_COUNT`, default 8: entries recorded after the trigger entry before freezing; legal range 0..2^DEPTH_LOG2-1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, same as CPU `clk`.
- `rst_n` in 1: asynchronous active-low reset.
- `cpuEn` in 1: CPU advanced this cycle; capture qualifier.
- `pc` in 32: word PC (byte address = pc<<2).
- `instr` in 32: instruction at `pc`.
- `trigger` in 1: stop-condition request, level-sampled.
- `rearm` in 1: discard contents and return to recording.
- `rdReq` in 1: pop oldest entry.
- `rdValid` out 1: `rdData` valid this cycle.
- `rdData` out 64: {pc, instr}.
- `count` out DEPTH_LOG2+1: valid entries held.
- `frozen` out 1: buffer stopped and readable.

## Operation
- States: ARMED, POST, FROZEN. Reset enters ARMED.
- ARMED:
  - On `cpuEn` (and entry not filtered), write {pc, instr} at `wrPtr`, increment `wrPtr` (mod depth), and saturate `count` at 2^DEPTH_LOG2. On wrap, the oldest entry is overwritten and `rdPtr` advances with `wrPtr`.
  - `trigger` together with a capture: that entry is stored. With POST_COUNT=0, go to FROZEN; otherwise load `postCnt`=POST_COUNT and go to POST.
  - `trigger` without a capture is ignored.
- POST:
  - Capture as in ARMED, and decrement `postCnt` on each capture. When the capture brings it to 0, go to FROZEN.
  - `trigger` is ignored.
- FROZEN:
  - No writes.
  - `rdReq` with `count`>0 reads the entry at `rdPtr`, then increments `rdPtr` and decrements `count`.
  - `rdReq` with `count`=0 is ignored.
- `rearm` in any state clears `count`, `wrPtr`, `rdPtr` and `postCnt`, suppresses any same-cycle capture, and enters ARMED. `rearm` beats a simultaneous `rdReq` (no `rdValid`) and a simultaneous `trigger`.
- `rdReq` outside FROZEN is ignored.
- Reset mid-operation: all state is discarded and the block enters ARMED. RAM contents are don't-care, because `count`=0 masks them.

## Timing
- Reset values: `rdValid`=0, `rdData`=0, `count`=0, `frozen`=0.
- Write: an entry is readable from the cycle after capture.
- Read latency is 1: `rdValid` is high exactly one cycle after an accepted `rdReq`. `rdData` holds its value until the next accepted read or reset.
- Back-to-back `rdReq` on consecutive cycles gives one entry per cycle.
- `frozen` rises the cycle after the final capture and falls the cycle after `rearm`.
- `count` updates the cycle after the event that changes it.

## Configuration
- `SM_TRACE_NOP_FILTER_EN`
  - Defined: cycles with `instr`==32'h0 are not captured and do not decrement `postCnt`. A `trigger` on such a cycle is ignored.
  - Undefined: every `cpuEn` cycle is captured, including nops.

## Structure
- Package `sm_trace_pkg`: state enum (ARMED/POST/FROZEN) and the `TRACE_ENTRY_W`=64 constant.
- Sub-module `sm_trace_ram`: simple dual-port synchronous RAM with 1 write and 1 read port, 1-cycle read latency, width `TRACE_ENTRY_W`, depth 2^DEPTH_LOG2.
- The top holds the FSM, pointers, `count` and `postCnt`.

## Test plan
- Reset, then 5 captures pc=0..4 with `trigger` on pc=2, POST_COUNT=2 → `frozen`=1 the cycle after pc=4, `count`=5. Reads return pc 0,1,2,3,4 in order, and `count`=0 after the last.
- DEPTH_LOG2=4, 20 captures pc=0..19, `trigger` on pc=19, POST_COUNT=0 → `count`=16, first read pc=4, last read pc=19.
- `cpuEn` low on alternating cycles, pc driven 0..9 each cycle → only entries with `cpuEn`=1 (pc 0,2,4,6,8) are stored.
- FROZEN with `count`=3, `rearm` and `rdReq` in the same cycle → next cycle `rdValid`=0, `count`=0, `frozen`=0, state ARMED.
- With `SM_TRACE_NOP_FILTER_EN`, stream instr {0x24020005, 0, 0, 0x00000021} → `count`=2 and reads return only the non-zero words. Without the macro, `count`=4.
- `rst_n` pulsed low during POST with `count`=7 → all outputs return to their reset values immediately, and recording restarts in ARMED after release.
